// File: rtl/rom_burst_reader.sv
// Burst initiator for a small combinational lookup ROM: walks a wrapping address
// range from start_addr and streams each registered ROM word over valid/ready.
module rom_burst_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rom_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int REM_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FIN
  } state_t;

  state_t           state;
  logic [REM_W-1:0] remaining;
  logic [REM_W-1:0] len_clamped;

  // Requests longer than the ROM depth are trimmed to one full pass.
  // NOTE: every output of a combinational block gets a value on every path;
  // assigning a default first keeps a latch from being inferred.
  always_comb begin
    len_clamped = REM_W'(DEPTH);
    if (len <= LEN_W'(DEPTH)) begin
      len_clamped = REM_W'(len);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              addr      <= start_addr;
              remaining <= len_clamped;
              state     <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end

        // addr has been stable since the previous edge, so the ROM word is settled.
        FETCH: begin
          out_data  <= rom_out;
          out_valid <= 1'b1;
          out_last  <= (remaining == REM_W'(1));
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              addr  <= addr + ADDR_W'(1);
              state <= FETCH;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Sequential initiator for the 8-entry × 4-bit combinational lookup ROM. On a start request it walks a burst of ROM addresses, beginning at a given address and wrapping modulo 8. It registers each ROM word and delivers it on a valid/ready output stream with a last-beat marker. It sits between control logic and the ROM, so consumers receive ROM contents as a flow-controlled stream rather than by driving addresses directly.

## Interface
- ADDR_W, 3, ROM address width; depth is 2**ADDR_W.
- DATA_W, 4, ROM word width.
- LEN_W, 4, burst-length width; must be ≥ ADDR_W+1 so that a full-depth burst is encodable.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  burst request; sampled only in IDLE.
- start_addr  input  ADDR_W  first ROM address of the burst.
- len  input  LEN_W  number of beats; legal range 0..2**ADDR_W; values above 2**ADDR_W are clamped to 2**ADDR_W.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a burst completes.
- addr  output  ADDR_W  registered address driven to the ROM `addr` input.
- rom_out  input  DATA_W  ROM `out`; combinational function of `addr`.
- out_data  output  DATA_W  registered ROM word.
- out_valid  output  1  `out_data` is valid.
- out_last  output  1  the current beat is the final beat of the burst; qualified by `out_valid`.
- out_ready  input  1  consumer accepts the beat when `out_valid` and `out_ready` are both high.

## Operation
- States: IDLE, FETCH, SEND, FIN.
- IDLE, start=1, len≠0: latch `addr`←start_addr and `remaining`←min(len, 2**ADDR_W); go to FETCH.
- IDLE, start=1, len=0: go to FIN; no beats are produced.
- IDLE, start=0: stay in IDLE.
- FETCH (exactly one cycle): capture `out_data`←rom_out; set `out_valid`=1; set `out_last`=(remaining==1); go to SEND.
- SEND: hold `out_data`, `out_valid` and `out_last` stable while out_ready=0.
- SEND, handshake with remaining>1: decrement `remaining`; `addr`←addr+1 (wraps 7→0, modulo 2**ADDR_W); `out_valid`←0; go to FETCH.
- SEND, handshake with remaining==1: `out_valid`←0, `out_last`←0; go to FIN.
- FIN (one cycle): done=1; go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `addr` holds its last value while in IDLE.
- Reset (asynchronous, including mid-burst): state=IDLE; addr=0, out_data=0, out_valid=0, out_last=0, done=0, busy=0, remaining=0. A partially delivered burst is abandoned, and no done pulse is issued for it.

## Timing
- start accepted at edge N: `addr` is valid from N+1 (FETCH) and `out_valid`=1 from N+2.
- Throughput: at most one beat per 2 cycles (FETCH + SEND) under continuous out_ready=1.
- Burst of L beats with out_ready tied high: start edge N, done high in cycle N+2L+1, IDLE at N+2L+2, next start accepted at edge N+2L+2.
- len=0: done high in cycle N+1.
- `busy` is high from N+1 through the done cycle inclusive.
- `done` and `out_valid` are never high in the same cycle.
- `rom_out` is sampled only at the FETCH edge. The ROM is purely combinational, so `addr` settles within that cycle and no extra wait state is needed.

## Test plan
- ROM modelled as rom_out = addr + 4'd3. Stimulus: start_addr=0, len=8, out_ready=1. Response: beats 3,4,5,6,7,8,9,A; out_last only on beat 8; done exactly 17 cycles after the start edge.
- Wrap: start_addr=6, len=3. Response: addr sequence 6,7,0; data 9,A,3; out_last on the third beat.
- Backpressure: len=2, out_ready held low for 5 cycles after the first valid. Response: out_data=first word and out_valid=1 stay stable for all 5 cycles; exactly 2 handshakes; no duplicate or lost beats.
- len=0 and len=9. Response: len=0 gives done one cycle after start with no out_valid. len=9 is clamped to 8 beats.
- Start while busy: pulse start with start_addr=5 during the second beat of a len=4 burst from address 1. Response: addresses 1,2,3,4 only; the pulse is ignored.
- Reset mid-burst: assert rst during SEND of beat 2. Response: all outputs 0 immediately (asynchronous); no done pulse. A new burst after reset deasserts runs correctly from its start_addr.
